// File: rtl/s3g_pkg.sv
// Shared constants and types for the S3G serial framing blocks.
package s3g_pkg;

  localparam logic [7:0] START_BYTE = 8'hD5;
  localparam logic [7:0] CRC_POLY   = 8'h8C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } s3g_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CRC     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

endpackage

// File: rtl/s3g_crc8.sv
// Combinational one-byte update of the reflected CRC8 (Maxim/iButton).
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/s3g_rx_ext.sv
// S3G packet receiver: frames D5/len/payload/crc byte streams from a UART
// into a single-entry output buffer with error reporting and statistics.
//
// state   | meaning
// IDLE    | hunting for START_BYTE, other bytes dropped
// LEN     | next byte is the payload length
// PAYLOAD | capturing payload bytes, CRC accumulating
// CRC     | next byte is the CRC; decides publish / discard
module s3g_rx_ext
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     buf_ack,
  output logic                     packet_done,
  output logic                     packet_error,
  output logic [2:0]               error_code,
  output logic [7:0]               payload_len,
  output logic                     buffer_valid,
  output logic [MAX_PAYLOAD*8-1:0] buf_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         good_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam int               BUF_W    = MAX_PAYLOAD * 8;
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN  = 8'(MAX_PAYLOAD);

  s3g_state_e       state_q;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [7:0]       crc_q;
  logic [BUF_W-1:0] cap_q;
  logic [TMR_W-1:0] tmr_q;
  logic             packet_done_q;
  logic             packet_error_q;
  logic [2:0]       error_code_q;
  logic [7:0]       payload_len_q;
  logic             buffer_valid_q;
  logic [BUF_W-1:0] buf_data_q;
  logic [CNT_W-1:0] good_q;
  logic [CNT_W-1:0] err_q;

  logic [7:0] crc_next;
  logic       fail_ev;
  logic [2:0] fail_code;
  logic       publish_ev;

  s3g_crc8 u_crc8 (
    .crc_in  (crc_q),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  // Packet outcome decode; the timer only matters on cycles without a byte.
  always_comb begin
    fail_ev    = 1'b0;
    fail_code  = ERR_NONE;
    publish_ev = 1'b0;
    if (rx_done) begin
      if (state_q == ST_LEN && rx_data > MAX_LEN) begin
        fail_ev   = 1'b1;
        fail_code = ERR_LEN;
      end else if (state_q == ST_CRC) begin
        if (rx_data != crc_q) begin
          fail_ev   = 1'b1;
          fail_code = ERR_CRC;
        end else if (buffer_valid_q && !buf_ack) begin
          fail_ev   = 1'b1;
          fail_code = ERR_OVERRUN;
        end else begin
          publish_ev = 1'b1;
        end
      end
    end else if (state_q != ST_IDLE && tmr_q == '0) begin
      fail_ev   = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      crc_q          <= '0;
      cap_q          <= '0;
      tmr_q          <= '0;
      packet_done_q  <= 1'b0;
      packet_error_q <= 1'b0;
      error_code_q   <= ERR_NONE;
      payload_len_q  <= '0;
      buffer_valid_q <= 1'b0;
      buf_data_q     <= '0;
      good_q         <= '0;
      err_q          <= '0;
    end else begin
      packet_done_q  <= 1'b0;
      packet_error_q <= 1'b0;

      if (buf_ack) buffer_valid_q <= 1'b0;

      if (state_q == ST_IDLE || rx_done) tmr_q <= TMR_LOAD;
      else if (tmr_q != '0)              tmr_q <= tmr_q - TMR_W'(1);

      if (rx_done) begin
        unique case (state_q)
          ST_IDLE: begin
            if (rx_data == START_BYTE) state_q <= ST_LEN;
          end
          ST_LEN: begin
            len_q <= rx_data;
            idx_q <= '0;
            crc_q <= '0;
            cap_q <= '0;
            if (rx_data == 8'd0)        state_q <= ST_CRC;
            else if (rx_data > MAX_LEN) state_q <= ST_IDLE;
            else                        state_q <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (idx_q == 8'(i)) cap_q[i*8 +: 8] <= rx_data;
            end
            crc_q <= crc_next;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= ST_CRC;
          end
          ST_CRC: begin
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (fail_ev) begin
        state_q <= ST_IDLE;
      end

      if (fail_ev) begin
        packet_error_q <= 1'b1;
        error_code_q   <= fail_code;
        if (err_q != '1) err_q <= err_q + CNT_W'(1);
      end

      // A coincident ack already cleared the old entry above; publish overrides it.
      if (publish_ev) begin
        packet_done_q  <= 1'b1;
        error_code_q   <= ERR_NONE;
        buffer_valid_q <= 1'b1;
        buf_data_q     <= cap_q;
        payload_len_q  <= len_q;
        if (good_q != '1) good_q <= good_q + CNT_W'(1);
      end
    end
  end

  assign packet_done  = packet_done_q;
  assign packet_error = packet_error_q;
  assign error_code   = error_code_q;
  assign payload_len  = payload_len_q;
  assign buffer_valid = buffer_valid_q;
  assign buf_data     = buf_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign good_count   = good_q;
  assign err_count    = err_q;

endmodule

// File: doc/s3g_rx_ext.md
S3G_RX_EXT -- requirements
Module: s3g_rx_ext

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 32, the maximum accepted payload length in bytes (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, the inter-byte timeout in clk cycles (must be >= 2).
REQ-003 SHALL have parameter CNT_W, default 16, the width of the statistics counters.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_data, input, 8 bits: received UART byte, valid when rx_done=1.
REQ-007 SHALL have port rx_done, input, 1 bit: one-cycle byte-valid strobe.
REQ-008 SHALL have port buf_ack, input, 1 bit: consumer releases the output buffer.
REQ-009 SHALL have port packet_done, output, 1 bit: one-cycle pulse when a good packet is published.
REQ-010 SHALL have port packet_error, output, 1 bit: one-cycle pulse when a packet is discarded.
REQ-011 SHALL have port error_code, output, 3 bits: 0 none, 1 CRC, 2 LEN, 3 TIMEOUT, 4 OVERRUN.
REQ-012 SHALL have port payload_len, output, 8 bits: length of the published packet.
REQ-013 SHALL have port buffer_valid, output, 1 bit: high while the output buffer holds an unacknowledged packet.
REQ-014 SHALL have port buf_data, output, MAX_PAYLOAD*8 bits: payload byte i on bits [8i+7:8i]; bytes >= payload_len read 0.
REQ-015 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-016 SHALL have ports good_count and err_count, output, CNT_W bits each: saturating counts of packet_done and packet_error pulses.

Function
REQ-017 SHALL implement FSM states IDLE, LEN, PAYLOAD and CRC, and act only in cycles where rx_done=1.
REQ-018 In IDLE, SHALL go to LEN on byte 0xD5, and SHALL silently ignore any other byte.
REQ-019 In LEN, SHALL go to CRC if the length is 0, and SHALL take error LEN and return to IDLE if the length exceeds MAX_PAYLOAD.
REQ-020 In all other LEN cases, SHALL go to PAYLOAD.
REQ-021 In PAYLOAD, SHALL store each byte into the capture buffer at an incrementing index and update the CRC; after byte len-1 it SHALL go to CRC.
REQ-022 The CRC SHALL be Maxim/iButton CRC8: reflected polynomial 0x8C, initial value 0x00, over payload bytes only, with a single-cycle byte update.
REQ-023 In CRC, a mismatch SHALL raise error CRC.
REQ-024 In CRC, a match while buffer_valid=1 and buf_ack=0 SHALL raise error OVERRUN.
REQ-025 In all other CRC-match cases, SHALL copy the capture buffer to buf_data, set payload_len, and set buffer_valid; the state SHALL then return to IDLE.
REQ-026 packet_done and packet_error SHALL assert exactly one cycle after the rx_done of the deciding byte, and never in the same cycle.
REQ-027 error_code SHALL update on each packet_error, clear to 0 on each packet_done, and hold otherwise.
REQ-028 While not in IDLE, an idle counter SHALL be cleared by each rx_done; on reaching TIMEOUT_CYCLES it SHALL raise error TIMEOUT and the FSM SHALL return to IDLE.
REQ-029 buf_ack SHALL clear buffer_valid on the next edge.
REQ-030 If buf_ack coincides with completion, the ack SHALL win and the new packet SHALL be published (buffer_valid stays 1).
REQ-031 buf_data and payload_len SHALL change only on publish.
REQ-032 good_count and err_count SHALL stick at all-ones rather than wrap.

Reset
REQ-033 On rst=0, all outputs, the counters, the buffers and the CRC SHALL go to 0 immediately, and the FSM SHALL go to IDLE, including mid-packet.
REQ-034 Reception SHALL resume with the first 0xD5 after rst returns high.

Structure
REQ-035 Package s3g_pkg SHALL hold START_BYTE 0xD5, CRC_POLY 0x8C, the FSM state encoding and the error-code constants.
REQ-036 Sub-module s3g_crc8 SHALL provide the combinational byte update (crc_in, data -> crc_out) and SHALL be reused by s3g_tx.
REQ-037 The design SHALL use no other sub-modules.

Verification
REQ-038 D5 03 01 02 03 D8 -> one packet_done pulse; payload_len=3; buf_data bytes 01,02,03; buffer_valid=1; good_count=1; error_code=0.
REQ-039 D5 03 01 02 03 CC -> packet_error with error_code=1; buffer contents unchanged; err_count=1.
REQ-040 D5 28 with MAX_PAYLOAD=32 -> packet_error, error_code=2, one cycle after the length byte; the following 01 02 are ignored in IDLE.
REQ-041 TIMEOUT_CYCLES=50, D5 03 01 then silence -> error_code=3 exactly 50 cycles after byte 01; a following good packet is accepted.
REQ-042 Two good packets with no buf_ack -> the second gives error_code=4 and the buffer keeps the first; pulsing buf_ack between them -> the second is published.
REQ-043 Byte 0D before D5 -> ignored with no error; rst low during PAYLOAD -> all outputs 0 and busy=0 with no clock edge.
